pry2oht_arb: RTL



---
 rtl/pry2oht_arb.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/pry2oht_arb.sv
// pry2oht_arb: registered priority-to-one-hot arbiter with fixed-priority or
// round-robin selection and a valid/ready grant register.
// Optional feature macro: PRY2OHT_ARB_LOCK_EN adds the lck port and the LOCKED
// state. When it is undefined the arbiter behaves as if lck were always 0.
// The search is a padded radix-SPLIT tree (IMPLEMENTATION=0) or a linear scan
// (any other value). Both give identical results.
module pry2oht_arb #(
    parameter int    WIDTH          = 32,
    parameter int    SPLIT          = 2,
    parameter string DIRECTION      = "LSB",
    parameter int    MODE           = 0,
    parameter int    IMPLEMENTATION = 0,
    localparam int   IDX_W          = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] req,
    output logic             gnt_vld,
    input  logic             gnt_rdy,
    output logic [WIDTH-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx
`ifdef PRY2OHT_ARB_LOCK_EN
    ,
    input  logic             lck
`endif
);

    // Tree geometry: pad the request vector up to RADIX**LEVELS leaves.
    localparam int  SPLIT_LG  = (SPLIT > 1) ? $clog2(SPLIT) : 1;
    localparam int  RADIX     = 1 << SPLIT_LG;
    localparam int  RAW_LG    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int  LEVELS    = (RAW_LG + SPLIT_LG - 1) / SPLIT_LG;
    localparam int  PIW       = LEVELS * SPLIT_LG;
    localparam int  PW        = 1 << PIW;
    localparam bit  MSB_FIRST = (DIRECTION == "MSB");

`ifdef PRY2OHT_ARB_LOCK_EN
    typedef enum logic [1:0] {IDLE, GRANT, LOCKED} state_t;
`else
    typedef enum logic {IDLE, GRANT} state_t;
`endif

    // Radix tree reduction over the padded vector, leaf 0 wins; returns {hit, leaf}.
    function automatic logic [PIW:0] tree_search(input logic [PW-1:0] vec);
        logic [PW-1:0]  hit;
        logic [PIW-1:0] pos [PW];
        logic           fh;
        logic [PIW-1:0] fp;
        int             n;
        hit = vec;
        for (int i = 0; i < PW; i++) pos[i] = PIW'(i);
        n = PW;
        for (int l = 0; l < LEVELS; l++) begin
            n = n / RADIX;
            for (int g = 0; g < PW / RADIX; g++) begin
                if (g < n) begin
                    fh = 1'b0;
                    fp = '0;
                    for (int c = RADIX - 1; c >= 0; c--) begin
                        if (hit[g*RADIX + c]) begin
                            fh = 1'b1;
                            fp = pos[g*RADIX + c];
                        end
                    end
                    hit[g] = fh;
                    pos[g] = fp;
                end
            end
        end
        return {hit[0], pos[0]};
    endfunction

    // Flat scan alternative, leaf 0 wins; returns {hit, leaf}.
    function automatic logic [PIW:0] linear_search(input logic [PW-1:0] vec);
        logic [PIW:0] r;
        r = '0;
        for (int i = PW - 1; i >= 0; i--) begin
            if (vec[i]) r = {1'b1, PIW'(i)};
        end
        return r;
    endfunction

    // Direction-aware search on a WIDTH-bit vector; returns {hit, physical index}.
    function automatic logic [IDX_W:0] search(input logic [WIDTH-1:0] v);
        logic [PW-1:0] pad;
        logic [PIW:0]  r;
        int            p;
        pad = '0;
        for (int i = 0; i < WIDTH; i++) pad[i] = MSB_FIRST ? v[WIDTH-1-i] : v[i];
        r = (IMPLEMENTATION != 0) ? linear_search(pad) : tree_search(pad);
        p = int'(r[PIW-1:0]);
        if (MSB_FIRST) p = WIDTH - 1 - p;
        return {r[PIW], IDX_W'(p)};
    endfunction

    // Round-robin mask after granting index i: bits strictly past i in priority order.
    function automatic logic [WIDTH-1:0] beyond(input logic [IDX_W-1:0] i);
        logic [WIDTH-1:0] m;
        for (int j = 0; j < WIDTH; j++) m[j] = MSB_FIRST ? (j < int'(i)) : (j > int'(i));
        return m;
    endfunction

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] msk;
    logic [WIDTH-1:0] msk_nxt;
    logic [WIDTH-1:0] eff_msk;
    logic [WIDTH-1:0] gnt_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic [IDX_W:0]   masked_res;
    logic [IDX_W:0]   full_res;
    logic [IDX_W:0]   sel_res;
    logic             ld;
    logic             xfer;
    logic             lock_hold;

    assign gnt_vld = (state != IDLE);
    assign ld      = !gnt_vld || gnt_rdy;
    assign xfer    = gnt_vld && gnt_rdy;

    // A transfer in this cycle moves the pointer before the same-cycle search.
    assign eff_msk    = xfer ? beyond(gnt_idx) : msk;
    assign masked_res = search(req & eff_msk);
    assign full_res   = search(req);
    assign sel_res    = ((MODE != 0) && masked_res[IDX_W]) ? masked_res : full_res;

    // While locked (or entering), the held index is the one being transferred.
`ifdef PRY2OHT_ARB_LOCK_EN
    assign lock_hold = xfer && lck && req[gnt_idx];
`else
    assign lock_hold = 1'b0;
`endif

    // Next-state, next-grant and pointer update; nothing changes unless loading.
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        idx_nxt   = gnt_idx;
        msk_nxt   = msk;
        if (ld) begin
            if (lock_hold) begin
`ifdef PRY2OHT_ARB_LOCK_EN
                state_nxt = LOCKED;
                msk_nxt   = (state == LOCKED) ? msk : eff_msk;
`endif
            end else begin
                msk_nxt = eff_msk;
                if (sel_res[IDX_W]) begin
                    state_nxt = GRANT;
                    idx_nxt   = sel_res[IDX_W-1:0];
                    gnt_nxt   = WIDTH'(1) << sel_res[IDX_W-1:0];
                end else begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                    gnt_nxt   = '0;
                end
            end
        end
    end

    // Grant register, state and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            gnt     <= '0;
            gnt_idx <= '0;
            msk     <= '1;
        end else begin
            state   <= state_nxt;
            gnt     <= gnt_nxt;
            gnt_idx <= idx_nxt;
            msk     <= msk_nxt;
        end
    end

endmodule
